gnr_node_lut: RTL
=================

# gnr_node_lut

Parametrised Boolean-network node for the GNR accelerator datapath. It holds LANES independent one-bit gene states. Each state is updated from K regulator inputs through a runtime-programmable truth table shared by all lanes. A per-lane update divider lets a lane evaluate only on every (div+1)-th start. The node reports per-lane change pulses and a node-level steady-state flag, which the network controller uses for attractor detection.

## Interface
Parameters:
- LANES, 2, number of independent state lanes (≥1)
- K, 2, regulator inputs per lane (1..6); truth table is 2^K bits
- DIV_W, 2, width of the update-divider setting
- TT_INIT, {2^K{…}} = 4'b0111 for K=2, truth table loaded at reset (NAND)

Ports:
- clk  in  1  clock; all state changes on the rising edge
- rst  in  1  reset, asynchronous, active-low (asserted at 0)
- reset_nos  in  1  synchronous reload of all lanes to init_state
- init_state  in  LANES  per-lane reload value
- start  in  LANES  per-lane update request, one bit per lane
- div  in  DIV_W  divider setting; a lane evaluates on every (div+1)-th start
- in_vec  in  LANES*K  lane i inputs at [i*K +: K]; bit K-1 of each slice is the index MSB
- cfg_we  in  1  truth-table write strobe
- cfg_tt  in  2^K  new truth table
- state  out  LANES  registered lane states
- changed  out  LANES  one-cycle pulse: the lane evaluated and its state flipped
- steady  out  1  registered; every lane has evaluated since the last reload, and no lane's latest evaluation changed its state

## Operation
- Per lane i:
  - idx = in_vec[i*K +: K]
  - next = tt[idx]
- Phase counter phase[i] (DIV_W bits) per lane.
- On start[i] with phase[i]==0: the lane evaluates.
  - state[i] <= next
  - phase[i] <= div
  - evaluated[i] <= 1
  - dirty[i] <= (next != state[i])
  - changed[i] <= (next != state[i])
- On start[i] with phase[i]!=0: phase[i] <= phase[i]-1 and state is held.
- With div=0, the lane evaluates on every start. With div=1, it evaluates, skips one start, then evaluates again.
- div is sampled only when a phase reload happens. Changing div mid-count does not alter the count already in progress.
- changed[i] is 0 in every cycle without an evaluation, including skipped starts.
- steady <= (&evaluated) & ~(|dirty), computed from the updated flag values. steady is registered, so it reflects the current cycle's evaluations one cycle later.
- reset_nos (sync):
  - state <= init_state
  - phase <= 0, so the first start after a reload evaluates
  - evaluated, dirty, changed <= 0
  - steady <= 0
  - Overrides start in the same cycle.
- Truth table: tt <= cfg_tt on cfg_we. Writes are allowed at any time and are not blocked by reset_nos.
  - An evaluation in the same cycle as cfg_we uses the old table.
  - reset_nos does not reset tt.
- Priority: rst > reset_nos > start. cfg_we is independent of start and reset_nos.
- Lanes are fully independent except for the shared tt and the steady reduction.

## Timing
- rst low: state=0, changed=0, steady=0, phase=0, evaluated=0, dirty=0, tt=TT_INIT, all immediately (asynchronous). Release is synchronised externally.
- Evaluation latency: state and changed are valid on the edge after the start cycle, i.e. 1 cycle.
- steady is valid on the edge after the start cycle, in the same cycle as the corresponding changed pulse.
- Table write latency: tt is updated on the cfg_we edge. The first evaluation to use the new table is a start in the cycle after cfg_we.
- reset_nos asserted mid-divider count discards the count. The next start evaluates.
- rst asserted mid-operation clears everything, including tt back to TT_INIT.
- No handshake: start is a level sampled per cycle. Holding start high for N cycles equals N starts.

## Test plan
- Reset and NAND default (LANES=2, K=2, div=0):
  - rst low -> state=00, steady=0.
  - Then reset_nos with init_state=2'b11, then start=11 with in_vec=4'b1111 -> state=00, changed=11, steady=0.
- Divider (div=1, lane 0):
  - reset_nos with init 0, then start[0] held 4 cycles with in_vec lane0=2'b00 -> lane 0 evaluates on starts 1 and 3.
  - state[0]=1 after start 1. changed[0] pulses only after start 1.
- Steady detection, both lanes:
  - in_vec=0000, init=11, starts every cycle -> first evaluation gives changed=00 and steady=1 one cycle later.
  - Then set lane1 in_vec=11 -> state[1]=0, changed[1]=1, steady=0 that cycle.
- Table write collision:
  - cfg_we with cfg_tt=4'b1000 (AND) in the same cycle as start, idx=3, state 1 -> result uses NAND, so state=0.
  - Next start with idx=3 -> state=1.
- Priority:
  - reset_nos and start in the same cycle -> state=init_state, changed=0.
  - rst low while div count is pending -> all outputs 0 and tt=TT_INIT.
- Parametrised build with LANES=4, K=3, DIV_W=3, div=7:
  - lane 2 evaluates on starts 1, 9 and 17 only.
  - Output follows the programmed tt bit at the index given by in_vec[8:6].

Source files
------------

// File: rtl/gnr_node_lut.sv
// Boolean-network node: LANES one-bit gene states updated through a shared,
// runtime-programmable K-input truth table, with per-lane update dividers.
module gnr_node_lut #(
   parameter int LANES = 2,
   parameter int K     = 2,
   parameter int DIV_W = 2,
   parameter logic [(1<<K)-1:0] TT_INIT = {1'b0, {((1<<K)-1){1'b1}}}
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 reset_nos,
   input  logic [LANES-1:0]     init_state,
   input  logic [LANES-1:0]     start,
   input  logic [DIV_W-1:0]     div,
   input  logic [LANES*K-1:0]   in_vec,
   input  logic                 cfg_we,
   input  logic [(1<<K)-1:0]    cfg_tt,
   output logic [LANES-1:0]     state,
   output logic [LANES-1:0]     changed,
   output logic                 steady
);

   localparam int TT_W = 1 << K;

   logic [TT_W-1:0]  tt_reg;
   logic [LANES-1:0] state_reg, changed_reg, evaluated_reg, dirty_reg;
   logic             steady_reg;

   logic [LANES-1:0] eval_now, lut_out;
   logic [LANES-1:0] state_next, changed_next, evaluated_next, dirty_next;
   logic             steady_next;

   genvar gi;
   generate
      for (gi = 0; gi < LANES; gi++) begin : g_lane
         logic [DIV_W-1:0] phase_reg;
         logic [DIV_W-1:0] phase_next;

         // Lookup always reads the pre-edge table, so a same-cycle write is not seen.
         assign lut_out[gi]  = tt_reg[in_vec[gi*K +: K]];
         assign eval_now[gi] = start[gi] && (phase_reg == '0);

         assign state_next[gi]     = reset_nos   ? init_state[gi] :
                                     eval_now[gi] ? lut_out[gi]   : state_reg[gi];
         assign changed_next[gi]   = !reset_nos && eval_now[gi] && (lut_out[gi] != state_reg[gi]);
         assign evaluated_next[gi] = !reset_nos && (evaluated_reg[gi] || eval_now[gi]);
         assign dirty_next[gi]     = reset_nos    ? 1'b0 :
                                     eval_now[gi] ? (lut_out[gi] != state_reg[gi]) : dirty_reg[gi];

         // div is only captured on a reload, so changing it never disturbs a running count.
         assign phase_next = reset_nos           ? '0 :
                             !start[gi]          ? phase_reg :
                             (phase_reg == '0)   ? div : phase_reg - DIV_W'(1);

         always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
               phase_reg <= '0;
            end else begin
               phase_reg <= phase_next;
            end
         end
      end
   endgenerate

   assign steady_next = (&evaluated_next) & ~(|dirty_next);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         tt_reg        <= TT_INIT;
         state_reg     <= '0;
         changed_reg   <= '0;
         evaluated_reg <= '0;
         dirty_reg     <= '0;
         steady_reg    <= 1'b0;
      end else begin
         if (cfg_we) begin
            tt_reg <= cfg_tt;
         end
         state_reg     <= state_next;
         changed_reg   <= changed_next;
         evaluated_reg <= evaluated_next;
         dirty_reg     <= dirty_next;
         steady_reg    <= steady_next;
      end
   end

   assign state   = state_reg;
   assign changed = changed_reg;
   assign steady  = steady_reg;

endmodule
